param_datapath: RTL and testbench

Parametrised successor to the 16-bit CPU datapath. It holds PC, SP, MAR, IR, MDR, an ALU result register with flags, and an NREG-entry register file, all steered by the control unit's load and select strobes. It adds auto-increment and auto-decrement of PC and SP, and a request/acknowledge memory-transaction FSM in place of a combinational bus. It sits between the control unit and the memory interface.

---
 rtl/param_datapath.sv | 177 +++++++++++++++++
 tb/tb_param_datapath.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_datapath.sv
// param_datapath: parametrised CPU datapath with register file, ALU,
// PC/SP auto-step and a request/acknowledge memory transaction FSM.
module param_datapath #(
  parameter int WIDTH = 16,
  parameter int NREG = 8,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_RESET = '1,
  localparam int RW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldIR,
  input  logic             ldMAR,
  input  logic             ldPC,
  input  logic             ldSP,
  input  logic             ldALUreg,
  input  logic             pc_inc,
  input  logic [1:0]       sp_op,
  input  logic [1:0]       mar_src,
  input  logic             ALUon,
  input  logic [2:0]       fnSelect,
  input  logic [RW-1:0]    rs_a,
  input  logic [RW-1:0]    rs_b,
  input  logic [RW-1:0]    rd,
  input  logic             reg_we,
  input  logic             wb_src,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [WIDTH-1:0] data_bus,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] addr_bus,
  output logic [WIDTH-1:0] wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ir,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] pc, sp, mar, ir_q, mdr, alu_q;
  logic [WIDTH-1:0] rf [NREG];
  logic [3:0]       flags_q;
  logic             we_q;

  logic [WIDTH-1:0] op_a, op_b, res, mar_nx;
  logic [WIDTH:0]   sum;
  logic             c_out, v_out;
  logic             start, ack_rd;

  assign op_a = rf[rs_a];
  assign op_b = rf[rs_b];

  always_comb begin
    res   = '0;
    sum   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    unique case (fnSelect)
      3'b000: begin
        sum   = {1'b0, op_a} + {1'b0, op_b};
        res   = sum[MSB:0];
        c_out = sum[WIDTH];
        v_out = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      3'b001: begin
        sum   = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
        res   = sum[MSB:0];
        c_out = sum[WIDTH];
        v_out = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      3'b010: res = op_a & op_b;
      3'b011: res = op_a | op_b;
      3'b100: res = op_a ^ op_b;
      3'b101: res = ~op_a;
      3'b110: begin
        res   = {op_a[MSB-1:0], 1'b0};
        c_out = op_a[MSB];
      end
      3'b111: begin
        res   = {1'b0, op_a[MSB:1]};
        c_out = op_a[0];
      end
    endcase
  end

  always_comb begin
    mar_nx = pc;
    unique case (mar_src)
      2'b00: mar_nx = pc;
      2'b01: mar_nx = sp;
      2'b10: mar_nx = alu_q;
      2'b11: mar_nx = ir_q;
    endcase
  end

  // A new transaction may start in IDLE or on the edge leaving DONE.
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    start    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy  = 1'b0;
        start = mem_rd | mem_wr;
        if (start) state_nx = S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        start    = mem_rd | mem_wr;
        state_nx = start ? S_REQ : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign ack_rd = mem_req & mem_ack & ~we_q;
  assign mem_we = mem_req & we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      pc      <= PC_RESET;
      sp      <= SP_RESET;
      mar     <= '0;
      ir_q    <= '0;
      mdr     <= '0;
      alu_q   <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (ldPC)        pc <= alu_q;
      else if (pc_inc) pc <= pc + ONE;
      if (ldSP)                sp <= alu_q;
      else if (sp_op == 2'b01) sp <= sp - ONE;
      else if (sp_op == 2'b10) sp <= sp + ONE;
      if (ldMAR && !busy) mar <= mar_nx;
      if (ldIR) ir_q <= data_bus;
      if (ALUon) begin
        flags_q <= {res == '0, res[MSB], c_out, v_out};
        if (ldALUreg) alu_q <= res;
      end
      if (reg_we) rf[rd] <= wb_src ? mdr : alu_q;
      if (start) begin
        we_q <= mem_wr & ~mem_rd;
        if (mem_wr && !mem_rd) mdr <= op_b;
      end else if (ack_rd) begin
        mdr <= data_bus;
      end
    end
  end

  assign addr_bus = mar;
  assign wdata    = mdr;
  assign ir       = ir_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_param_datapath.sv
// tb_param_datapath: directed stimulus against a behavioural model,
// compared every cycle, plus literal checks that pin the model.
module tb_param_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldIR, ldMAR, ldPC, ldSP, ldALUreg, pc_inc;
  logic [1:0]  sp_op, mar_src;
  logic        ALUon;
  logic [2:0]  fnSelect;
  logic [2:0]  rs_a, rs_b, rd;
  logic        reg_we, wb_src, mem_rd, mem_wr, mem_ack;
  logic [15:0] data_bus;
  logic [15:0] addr_bus, wdata, ir;
  logic        mem_req, mem_we, busy, done;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_datapath dut (
    .clk(clk), .rst(rst),
    .ldIR(ldIR), .ldMAR(ldMAR), .ldPC(ldPC), .ldSP(ldSP),
    .ldALUreg(ldALUreg), .pc_inc(pc_inc), .sp_op(sp_op),
    .mar_src(mar_src), .ALUon(ALUon), .fnSelect(fnSelect),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .reg_we(reg_we),
    .wb_src(wb_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .data_bus(data_bus), .mem_ack(mem_ack),
    .addr_bus(addr_bus), .wdata(wdata), .mem_req(mem_req),
    .mem_we(mem_we), .busy(busy), .done(done), .ir(ir),
    .flags(flags)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Returns {Z,N,C,V,result} computed with plain integer arithmetic.
  function automatic logic [19:0] alu_model(input logic [2:0] fn,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    int ua, ub, sa, sb, full, sr;
    logic [15:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    c = 1'b0;
    v = 1'b0;
    r = '0;
    case (fn)
      3'd0: begin
        full = ua + ub;
        r = 16'(full);
        c = full >= 65536;
        sr = sa + sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        full = ua + (65535 - ub) + 1;
        r = 16'(full);
        c = full >= 65536;
        sr = sa - sb;
        v = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 16'(65535 - ua);
      3'd6: begin
        r = 16'((ua * 2) % 65536);
        c = ua >= 32768;
      end
      default: begin
        r = 16'(ua / 2);
        c = (ua % 2) == 1;
      end
    endcase
    return {r == 16'd0, r[15], c, v, r};
  endfunction

  // Model state; m_ph: 0 no transaction, 1 awaiting ack, 2 completing.
  logic [15:0] m_pc, m_sp, m_mar, m_ir, m_mdr, m_alu;
  logic [15:0] m_rf [8];
  logic [3:0]  m_flags;
  int          m_ph;
  logic        m_wr;
  bit          m_valid = 0;

  always @(posedge clk) begin : model
    logic [19:0] a;
    logic [15:0] n_pc, n_sp, n_mar, n_mdr, n_alu;
    int n_ph;
    logic n_wr;
    if (rst) begin
      m_pc = 16'h0000; m_sp = 16'hFFFF; m_mar = '0; m_ir = '0;
      m_mdr = '0; m_alu = '0; m_flags = '0; m_ph = 0; m_wr = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_valid = 1;
    end else begin
      a = alu_model(fnSelect, m_rf[rs_a], m_rf[rs_b]);
      n_pc = ldPC ? m_alu : (pc_inc ? m_pc + 16'd1 : m_pc);
      n_sp = m_sp;
      if (ldSP) n_sp = m_alu;
      else if (sp_op == 2'd1) n_sp = m_sp - 16'd1;
      else if (sp_op == 2'd2) n_sp = m_sp + 16'd1;
      n_mar = m_mar;
      if (ldMAR && m_ph == 0)
        case (mar_src)
          2'd0: n_mar = m_pc;
          2'd1: n_mar = m_sp;
          2'd2: n_mar = m_alu;
          default: n_mar = m_ir;
        endcase
      n_alu = (ALUon && ldALUreg) ? a[15:0] : m_alu;
      n_mdr = m_mdr;
      n_ph = m_ph;
      n_wr = m_wr;
      if (m_ph == 1) begin
        if (mem_ack) begin
          n_ph = 2;
          if (!m_wr) n_mdr = data_bus;
        end
      end else if (mem_rd || mem_wr) begin
        n_ph = 1;
        n_wr = mem_wr && !mem_rd;
        if (n_wr) n_mdr = m_rf[rs_b];
      end else begin
        n_ph = 0;
      end
      if (reg_we) m_rf[rd] = wb_src ? m_mdr : m_alu;
      if (ALUon) m_flags = a[19:16];
      if (ldIR) m_ir = data_bus;
      m_pc = n_pc; m_sp = n_sp; m_mar = n_mar; m_alu = n_alu;
      m_mdr = n_mdr; m_ph = n_ph; m_wr = n_wr;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("addr_bus", 32'(addr_bus), 32'(m_mar));
      chk("wdata", 32'(wdata), 32'(m_mdr));
      chk("ir", 32'(ir), 32'(m_ir));
      chk("flags", 32'(flags), 32'(m_flags));
      chk("mem_req", 32'(mem_req), 32'(m_ph == 1));
      chk("mem_we", 32'(mem_we), 32'(m_ph == 1 && m_wr));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("done", 32'(done), 32'(m_ph == 2));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic alu(input logic [2:0] fn, input logic [2:0] a,
                     input logic [2:0] b, input logic ld);
    fnSelect = fn; rs_a = a; rs_b = b; ALUon = 1'b1; ldALUreg = ld;
    step();
    ALUon = 1'b0; ldALUreg = 1'b0;
  endtask

  task automatic mar(input logic [1:0] src);
    ldMAR = 1'b1; mar_src = src;
    step();
    ldMAR = 1'b0;
  endtask

  task automatic load_reg(input logic [2:0] idx, input logic [15:0] v);
    mem_rd = 1'b1;
    step();
    mem_rd = 1'b0; mem_ack = 1'b1; data_bus = v;
    step();
    mem_ack = 1'b0;
    step();
    reg_we = 1'b1; wb_src = 1'b1; rd = idx;
    step();
    reg_we = 1'b0; wb_src = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ldIR = 0; ldMAR = 0; ldPC = 0; ldSP = 0; ldALUreg = 0;
    pc_inc = 0; sp_op = 0; mar_src = 0; ALUon = 0; fnSelect = 0;
    rs_a = 0; rs_b = 0; rd = 0; reg_we = 0; wb_src = 0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; data_bus = 0;
    step(); step();
    rst = 1'b0;

    // Preload PC=5, SP=3, then reset for two cycles
    load_reg(3'd1, 16'h0005);
    alu(3'b011, 3'd1, 3'd0, 1'b1);
    ldPC = 1'b1; step(); ldPC = 1'b0;
    load_reg(3'd2, 16'h0003);
    alu(3'b011, 3'd2, 3'd0, 1'b1);
    ldSP = 1'b1; step(); ldSP = 1'b0;
    mar(2'b00);
    chk("pc_preload", 32'(addr_bus), 32'h0005);
    mar(2'b01);
    chk("sp_preload", 32'(addr_bus), 32'h0003);
    rst = 1'b1; step(); step(); rst = 1'b0;
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    mar(2'b00);
    chk("rst_pc", 32'(addr_bus), 32'h0000);
    mar(2'b01);
    chk("rst_sp", 32'(addr_bus), 32'hFFFF);

    // ALU add overflow, equal subtract
    load_reg(3'd1, 16'h7FFF);
    load_reg(3'd2, 16'h0001);
    alu(3'b000, 3'd1, 3'd2, 1'b1);
    chk("add_flags", 32'(flags), 32'b0101);
    mar(2'b10);
    chk("add_result", 32'(addr_bus), 32'h8000);
    alu(3'b001, 3'd1, 3'd1, 1'b0);
    chk("sub_eq_flags", 32'(flags), 32'b1010);

    // Every function over a few operand pairs; model checks the rest
    load_reg(3'd6, 16'h8001);
    load_reg(3'd7, 16'h8000);
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 8; f++) begin
        alu(3'(f), (p == 0) ? 3'd1 : (p == 1) ? 3'd6 : 3'd7,
            (p == 0) ? 3'd2 : (p == 1) ? 3'd7 : 3'd6, 1'b1);
        mar(2'b10);
      end
    end
    chk("shr_8000", 32'(addr_bus), 32'h4000);

    // Write-back of ALUreg with same-cycle read of the old value
    fnSelect = 3'b100; rs_a = 3'd5; rs_b = 3'd5; ALUon = 1'b1;
    reg_we = 1'b1; wb_src = 1'b0; rd = 3'd5;
    step();
    ALUon = 1'b0; reg_we = 1'b0;
    chk("rw_old_flags", 32'(flags), 32'b1000);
    alu(3'b011, 3'd5, 3'd0, 1'b1);
    chk("rw_new_flags", 32'(flags), 32'b0000);

    // IR load and MAR from IR
    ldIR = 1'b1; data_bus = 16'h5A5A; step(); ldIR = 1'b0;
    chk("ir_load", 32'(ir), 32'h5A5A);
    mar(2'b11);
    chk("mar_ir", 32'(addr_bus), 32'h5A5A);

    // Stack wrap and ldSP priority
    alu(3'b000, 3'd0, 3'd0, 1'b1);
    ldSP = 1'b1; step(); ldSP = 1'b0;
    sp_op = 2'b01; step(); sp_op = 2'b00;
    mar(2'b01);
    chk("sp_dec_wrap", 32'(addr_bus), 32'hFFFF);
    sp_op = 2'b10; step(); sp_op = 2'b00;
    mar(2'b01);
    chk("sp_inc_wrap", 32'(addr_bus), 32'h0000);
    ldSP = 1'b1; sp_op = 2'b01; step(); ldSP = 1'b0; sp_op = 2'b00;
    mar(2'b01);
    chk("ldsp_wins", 32'(addr_bus), 32'h0000);
    pc_inc = 1'b1; step(); step(); pc_inc = 1'b0;
    mar(2'b00);
    chk("pc_inc", 32'(addr_bus), 32'h0002);

    // Read transaction with three wait cycles
    load_reg(3'd4, 16'h0010);
    alu(3'b011, 3'd4, 3'd0, 1'b1);
    ldPC = 1'b1; step(); ldPC = 1'b0;
    mar(2'b00);
    chk("rd_addr", 32'(addr_bus), 32'h0010);
    mem_rd = 1'b1; step(); mem_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd_req_held", 32'(mem_req), 32'h1);
      mem_ack = (i == 3);
      mem_rd = (i == 1);
      ldMAR = (i == 2);
      data_bus = (i == 3) ? 16'hABCD : 16'h1111;
      step();
      mem_rd = 1'b0; ldMAR = 1'b0;
    end
    mem_ack = 1'b0;
    chk("rd_done", 32'(done), 32'h1);
    chk("rd_req_low", 32'(mem_req), 32'h0);
    chk("rd_mdr", 32'(wdata), 32'hABCD);
    chk("rd_addr_kept", 32'(addr_bus), 32'h0010);
    step();
    chk("rd_done_once", 32'(done), 32'h0);
    chk("rd_idle", 32'(busy), 32'h0);

    // Write with immediate ack, then back-to-back read from DONE
    load_reg(3'd3, 16'h1234);
    rs_b = 3'd3; mem_wr = 1'b1; step(); mem_wr = 1'b0;
    chk("wr_data", 32'(wdata), 32'h1234);
    chk("wr_we", 32'(mem_we), 32'h1);
    chk("wr_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("wr_done", 32'(done), 32'h1);
    mem_rd = 1'b1; step(); mem_rd = 1'b0;
    chk("b2b_req", 32'(mem_req), 32'h1);
    chk("b2b_rd_we", 32'(mem_we), 32'h0);
    mem_ack = 1'b1; data_bus = 16'h00C3; step(); mem_ack = 1'b0;
    step();
    chk("b2b_mdr", 32'(wdata), 32'h00C3);

    // Reset during REQ, then a new request right after release
    mem_rd = 1'b1; step(); mem_rd = 1'b0;
    chk("rr_req", 32'(mem_req), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rr_req_low", 32'(mem_req), 32'h0);
    chk("rr_no_done", 32'(done), 32'h0);
    chk("rr_mdr_clr", 32'(wdata), 32'h0);
    mem_rd = 1'b1; step(); mem_rd = 1'b0;
    chk("rr_new_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; data_bus = 16'h0042; step(); mem_ack = 1'b0;
    step();
    chk("rr_new_mdr", 32'(wdata), 32'h0042);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
